ahb_lite_slave_mem: RTL and testbench

//   Parametrised AHB-lite slave memory: sits behind ahb_inf as the DUT-side target for the AHB_lite env.

---
 rtl/ahb_lite_slave_mem_if.sv | 29 ++
 rtl/ahb_lite_slave_mem.sv | 156 +++++++++++++++
 tb/tb_ahb_lite_slave_mem.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/ahb_lite_slave_mem_if.sv
// AHB-lite bus bundle between a master and the slave memory.
// Clock and reset are plain ports on the modules that use this interface.
interface ahb_lite_slave_mem_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  hsel;
  logic [ADDR_WIDTH-1:0] haddr;
  logic [1:0]            htrans;
  logic                  hwrite;
  logic [2:0]            hsize;
  logic [2:0]            hburst;
  logic [3:0]            hprot;
  logic                  hready;
  logic [DATA_WIDTH-1:0] hwdata;
  logic [DATA_WIDTH-1:0] hrdata;
  logic                  hreadyout;
  logic                  hresp;

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hready, hwdata,
    input  hrdata, hreadyout, hresp
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hready, hwdata,
    output hrdata, hreadyout, hresp
  );
endinterface

// File: rtl/ahb_lite_slave_mem.sv
// AHB-lite slave memory with programmable wait states, byte lanes and two-cycle ERROR responses.
// Read data is registered; a read accepted during a write commit to the same word sees the merged word.
module ahb_lite_slave_mem #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    MEM_DEPTH   = 256,
  parameter int                    WAIT_STATES = 0,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0
) (
  input logic                hclk,
  input logic                hreset,
  ahb_lite_slave_mem_if.slave bus
);

  localparam int BYTES          = DATA_WIDTH / 8;
  localparam int LSB            = $clog2(BYTES);
  localparam int IDX_W          = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam longint MEM_BYTES  = longint'(MEM_DEPTH) * longint'(BYTES);
  localparam logic [3:0] WS_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

  function automatic logic [DATA_WIDTH-1:0] lane_merge(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] new_word,
    input logic [BYTES-1:0]      be
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_word;
    for (int i = 0; i < BYTES; i++) begin
      if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  state_t                state_q, state_d;
  logic [3:0]            cnt_q;
  logic                  ready_q;
  logic                  resp_o;
  logic                  acc_p0;
  logic                  err_p0;
  logic [ADDR_WIDTH-1:0] offset_p0;
  logic [7:0]            amask_p0;
  logic [2:0]            lane_p0;
  logic [IDX_W-1:0]      idx_p0;
  logic [BYTES-1:0]      be_p0;

  logic [IDX_W-1:0]      idx_p1;
  logic [BYTES-1:0]      be_p1;
  logic                  write_p1;

  logic                  commit;
  logic                  load_acc;
  logic                  load_wait;
  logic [IDX_W-1:0]      rd_idx;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] hrdata_q;

  logic                  unused_ok;
  assign unused_ok = ^{bus.hburst, bus.hprot};

  // Address phase: decode, range/alignment/size checks, byte enables
  assign ready_q   = !((state_q == S_WAIT) || (state_q == S_ERR1));
  assign acc_p0    = bus.hsel && bus.hready && bus.htrans[1] && ready_q;
  assign offset_p0 = bus.haddr - BASE_ADDR;
  assign amask_p0  = (8'd1 << bus.hsize) - 8'd1;
  assign lane_p0   = 3'(bus.haddr[LSB-1:0]);
  assign idx_p0    = offset_p0[LSB +: IDX_W];
  assign err_p0    = (bus.haddr < BASE_ADDR)
                   || (offset_p0 >= ADDR_WIDTH'(MEM_BYTES))
                   || (|(bus.haddr[7:0] & amask_p0))
                   || (bus.hsize > 3'(LSB));

  always_comb begin
    for (int i = 0; i < BYTES; i++) begin
      be_p0[i] = ((3'(i) ^ lane_p0) >> bus.hsize) == 3'd0;
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= ((state_q == S_WAIT) && (state_d == S_WAIT)) ? cnt_q + 4'd1 : 4'd0;
    end
  end

  always_comb begin
    state_d = state_q;
    resp_o  = 1'b0;
    case (state_q)
      S_WAIT: if (cnt_q == WS_LAST) state_d = S_DATA;
      S_ERR1: begin
        resp_o  = 1'b1;
        state_d = S_ERR2;
      end
      S_ERR2: resp_o = 1'b1;
      default: ;
    endcase
    // Ready states (IDLE, DATA, ERR2) may take the next transfer back-to-back
    if (ready_q) begin
      if (acc_p0) begin
        if (err_p0)                state_d = S_ERR1;
        else if (WAIT_STATES > 0)  state_d = S_WAIT;
        else                       state_d = S_DATA;
      end else begin
        state_d = S_IDLE;
      end
    end
  end

  // Data phase: latched transfer attributes (master may change bus during WAIT)
  always_ff @(posedge hclk) begin
    if (acc_p0) begin
      idx_p1 <= idx_p0;
      be_p1  <= be_p0;
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset)      write_p1 <= 1'b0;
    else if (acc_p0) write_p1 <= bus.hwrite;
  end

  assign commit = (state_q == S_DATA) && write_p1 && !hreset;

  always_ff @(posedge hclk) begin
    if (commit) begin
      for (int i = 0; i < BYTES; i++) begin
        if (be_p1[i]) mem[idx_p1][8*i +: 8] <= bus.hwdata[8*i +: 8];
      end
    end
  end

  // Read fetch: at the accept edge with no wait states, otherwise at the last WAIT edge
  assign load_acc  = acc_p0 && !err_p0 && !bus.hwrite && (WAIT_STATES == 0);
  assign load_wait = (state_q == S_WAIT) && (cnt_q == WS_LAST) && !write_p1;
  assign rd_idx    = load_wait ? idx_p1 : idx_p0;
  assign rd_word   = (commit && (rd_idx == idx_p1))
                   ? lane_merge(mem[rd_idx], bus.hwdata, be_p1)
                   : mem[rd_idx];

  always_ff @(posedge hclk) begin
    if (hreset)                     hrdata_q <= '0;
    else if (load_acc || load_wait) hrdata_q <= rd_word;
  end

  assign bus.hrdata    = hrdata_q;
  assign bus.hreadyout = ready_q;
  assign bus.hresp     = resp_o;

endmodule

// File: tb/tb_ahb_lite_slave_mem.sv
// Scoreboard bench: three slave instances (0, 2 and 3 wait states) on one shared master driver;
// expectations are queued at address-phase acceptance and checked when the data phase completes.
module tb_ahb_lite_slave_mem;

  logic        hclk = 1'b0;
  logic        hreset;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  int          sel;

  logic        rdy, resp;
  logic [31:0] rdata;

  int n_chk = 0;
  int n_err = 0;

  always #5 hclk = ~hclk;

  ahb_lite_slave_mem_if bus0 ();
  ahb_lite_slave_mem_if bus2 ();
  ahb_lite_slave_mem_if bus3 ();

  assign bus0.hsel = hsel && (sel == 0);
  assign bus2.hsel = hsel && (sel == 1);
  assign bus3.hsel = hsel && (sel == 2);
  assign {bus0.haddr, bus2.haddr, bus3.haddr}    = {3{haddr}};
  assign {bus0.htrans, bus2.htrans, bus3.htrans} = {3{htrans}};
  assign {bus0.hwrite, bus2.hwrite, bus3.hwrite} = {3{hwrite}};
  assign {bus0.hsize, bus2.hsize, bus3.hsize}    = {3{hsize}};
  assign {bus0.hburst, bus2.hburst, bus3.hburst} = {3{3'b000}};
  assign {bus0.hprot, bus2.hprot, bus3.hprot}    = {3{4'b0011}};
  assign {bus0.hready, bus2.hready, bus3.hready} = {3{rdy}};
  assign {bus0.hwdata, bus2.hwdata, bus3.hwdata} = {3{hwdata}};

  always_comb begin
    rdy   = bus0.hreadyout;
    resp  = bus0.hresp;
    rdata = bus0.hrdata;
    case (sel)
      1: begin rdy = bus2.hreadyout; resp = bus2.hresp; rdata = bus2.hrdata; end
      2: begin rdy = bus3.hreadyout; resp = bus3.hresp; rdata = bus3.hrdata; end
      default: ;
    endcase
  end

  ahb_lite_slave_mem #(.WAIT_STATES(0)) u_dut0 (.hclk(hclk), .hreset(hreset), .bus(bus0));
  ahb_lite_slave_mem #(.WAIT_STATES(2)) u_dut2 (.hclk(hclk), .hreset(hreset), .bus(bus2));
  ahb_lite_slave_mem #(.WAIT_STATES(3)) u_dut3 (.hclk(hclk), .hreset(hreset), .bus(bus3));

  typedef struct {
    string       tag;
    logic        wr;
    logic [31:0] data;
    logic        err;
    int          waits;
  } exp_t;

  exp_t sb[$];
  int   low_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Data-phase monitor, sampled 1 time unit after each rising edge
  initial begin
    exp_t e;
    forever begin
      @(posedge hclk);
      #1;
      if (sb.size() > 0) begin
        if (!rdy) begin
          chk({sb[0].tag, "_stall_resp"}, 64'(resp), 64'(sb[0].err));
          low_cnt++;
        end else begin
          e = sb.pop_front();
          chk({e.tag, "_waits"}, 64'(low_cnt), 64'(e.waits));
          chk({e.tag, "_resp"}, 64'(resp), 64'(e.err));
          if (!e.wr && !e.err) chk({e.tag, "_rdata"}, 64'(rdata), 64'(e.data));
          low_cnt = 0;
        end
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after acceptance with hwdata driven
  task automatic issue(input string tag, input logic [31:0] a, input logic wr, input logic [2:0] sz,
                       input logic [31:0] wd, input logic [31:0] exp_d, input logic err, input int waits);
    exp_t e;
    logic ready_now;
    int   n;
    logic ok;
    hsel = 1'b1; htrans = 2'b10; haddr = a; hwrite = wr; hsize = sz;
    n  = 0;
    ok = 1'b1;
    forever begin
      ready_now = rdy;
      @(posedge hclk);
      if (ready_now) break;
      n++;
      if (n > 50) begin
        chk({tag, "_accept_timeout"}, 64'(n), 64'd0);
        ok = 1'b0;
        break;
      end
      @(negedge hclk);
    end
    if (ok) begin
      e.tag = tag; e.wr = wr; e.data = exp_d; e.err = err; e.waits = waits;
      sb.push_back(e);
    end
    @(negedge hclk);
    hwdata = wd; hsel = 1'b0; htrans = 2'b00;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 100) begin
      @(negedge hclk);
      n++;
    end
    chk("drain_pending", 64'(sb.size()), 64'd0);
    sb.delete();
    low_cnt = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    hreset = 1'b1; sel = 0; hsel = 1'b0; haddr = '0; htrans = 2'b00;
    hwrite = 1'b0; hsize = 3'd2; hwdata = '0;
    repeat (2) @(posedge hclk);
    @(negedge hclk);
    hreset = 1'b0;

    // Reset state of all instances
    chk("rst0_ready", 64'(bus0.hreadyout), 64'd1);
    chk("rst0_resp",  64'(bus0.hresp),     64'd0);
    chk("rst0_rdata", 64'(bus0.hrdata),    64'd0);
    chk("rst2_ready", 64'(bus2.hreadyout), 64'd1);
    chk("rst2_resp",  64'(bus2.hresp),     64'd0);
    chk("rst2_rdata", 64'(bus2.hrdata),    64'd0);
    chk("rst3_ready", 64'(bus3.hreadyout), 64'd1);
    chk("rst3_resp",  64'(bus3.hresp),     64'd0);
    chk("rst3_rdata", 64'(bus3.hrdata),    64'd0);

    // Zero wait states: write then back-to-back read of the same word (forwarding)
    sel = 0;
    issue("w04",  32'h04, 1'b1, 3'd2, 32'hDEADBEEF, 32'h0,        1'b0, 0);
    issue("r04",  32'h04, 1'b0, 3'd2, 32'h0,        32'hDEADBEEF, 1'b0, 0);
    drain();

    // Byte and halfword lanes, each read forwarded from the preceding sub-word write
    issue("w08",  32'h08, 1'b1, 3'd2, 32'h11223344, 32'h0,        1'b0, 0);
    issue("wb09", 32'h09, 1'b1, 3'd0, 32'h0000AA00, 32'h0,        1'b0, 0);
    issue("r08a", 32'h08, 1'b0, 3'd2, 32'h0,        32'h1122AA44, 1'b0, 0);
    issue("wh0a", 32'h0A, 1'b1, 3'd1, 32'h55660000, 32'h0,        1'b0, 0);
    issue("r08b", 32'h08, 1'b0, 3'd2, 32'h0,        32'h5566AA44, 1'b0, 0);
    drain();

    // Write-after-write to the same word: second wins on the overlapping lane
    issue("w0c",  32'h0C, 1'b1, 3'd2, 32'hAAAAAAAA, 32'h0,        1'b0, 0);
    issue("wb0c", 32'h0C, 1'b1, 3'd0, 32'h000000BB, 32'h0,        1'b0, 0);
    issue("r0c",  32'h0C, 1'b0, 3'd2, 32'h0,        32'hAAAAAABB, 1'b0, 0);
    drain();

    // Error responses: out of range, misaligned, oversized; word 0 must stay intact
    issue("w00",  32'h00,  1'b1, 3'd2, 32'h01020304, 32'h0,        1'b0, 0);
    issue("eoor", 32'd1024, 1'b0, 3'd2, 32'h0,       32'h0,        1'b1, 1);
    issue("emis", 32'h02,  1'b1, 3'd2, 32'hFFFFFFFF, 32'h0,        1'b1, 1);
    issue("ebig", 32'h00,  1'b1, 3'd3, 32'hFFFFFFFF, 32'h0,        1'b1, 1);
    issue("r00",  32'h00,  1'b0, 3'd2, 32'h0,        32'h01020304, 1'b0, 0);
    drain();

    // Two wait states
    sel = 1;
    issue("ws2_w00", 32'h00, 1'b1, 3'd2, 32'hA5A5A5A5, 32'h0,        1'b0, 2);
    issue("ws2_r00", 32'h00, 1'b0, 3'd2, 32'h0,        32'hA5A5A5A5, 1'b0, 2);
    issue("ws2_wb",  32'h03, 1'b1, 3'd0, 32'h7E000000, 32'h0,        1'b0, 2);
    issue("ws2_r00b", 32'h00, 1'b0, 3'd2, 32'h0,       32'h7EA5A5A5, 1'b0, 2);
    drain();

    // Three wait states: reset during the WAIT of a write aborts it
    sel = 2;
    issue("ws3_w10", 32'h10, 1'b1, 3'd2, 32'h12345678, 32'h0,        1'b0, 3);
    issue("ws3_r10", 32'h10, 1'b0, 3'd2, 32'h0,        32'h12345678, 1'b0, 3);
    drain();
    issue("ws3_wab", 32'h10, 1'b1, 3'd2, 32'hCAFEF00D, 32'h0,        1'b0, 3);
    sb.delete();
    low_cnt = 0;
    hreset = 1'b1;
    @(negedge hclk);
    hreset = 1'b0;
    chk("abort_ready", 64'(bus3.hreadyout), 64'd1);
    chk("abort_resp",  64'(bus3.hresp),     64'd0);
    chk("abort_rdata", 64'(bus3.hrdata),    64'd0);
    issue("ws3_r10b", 32'h10, 1'b0, 3'd2, 32'h0, 32'h12345678, 1'b0, 3);
    drain();

    repeat (2) @(negedge hclk);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
